// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures operand-selected instructions from decode and holds them for EX.
// Optional second (skid) entry enabled by defining ID_EX_SKID_EN; IN_READY is then a flop.
module id_ex_stage_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [XLEN-1:0]   IN_PC,
  input  logic [XLEN-1:0]   IN_RS1_DATA,
  input  logic [XLEN-1:0]   IN_RS2_DATA,
  input  logic [XLEN-1:0]   IN_IMM,
  input  logic [4:0]        IN_ALU_SEL,
  input  logic              IN_SRC1_PC,
  input  logic              IN_SRC2_IMM,
  input  logic [2:0]        IN_FUNC3,
  input  logic [4:0]        IN_RD,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [XLEN-1:0]   OUT_OP1,
  output logic [XLEN-1:0]   OUT_OP2,
  output logic [4:0]        OUT_ALU_SEL,
  output logic [XLEN-1:0]   OUT_PC,
  output logic [XLEN-1:0]   OUT_STORE_DATA,
  output logic [2:0]        OUT_FUNC3,
  output logic [4:0]        OUT_RD,
  output logic [CTRL_W-1:0] OUT_CTRL
);

  typedef struct packed {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   store_data;
    logic [4:0]        alu_sel;
    logic [2:0]        func3;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t in_entry;
  entry_t main_q;
  logic   main_v;
  logic   in_fire;
  logic   out_fire;

  // Operands are resolved once at capture so EX never sees the select flags.
  always_comb begin
    in_entry.op1        = IN_SRC1_PC  ? IN_PC  : IN_RS1_DATA;
    in_entry.op2        = IN_SRC2_IMM ? IN_IMM : IN_RS2_DATA;
    in_entry.pc         = IN_PC;
    in_entry.store_data = IN_RS2_DATA;
    in_entry.alu_sel    = IN_ALU_SEL;
    in_entry.func3      = IN_FUNC3;
    in_entry.rd         = IN_RD;
    in_entry.ctrl       = IN_CTRL;
  end

  assign out_fire = main_v && OUT_READY;

`ifdef ID_EX_SKID_EN
  entry_t skid_q;
  logic   skid_empty;

  assign IN_READY = skid_empty;
  assign in_fire  = IN_VALID && skid_empty;

  // Skid is only ever occupied while main is occupied, so it drains into main first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_v     <= 1'b0;
      skid_empty <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (FLUSH) begin
      main_v     <= 1'b0;
      skid_empty <= 1'b1;
    end else if (!main_v || out_fire) begin
      if (!skid_empty) begin
        main_q     <= skid_q;
        main_v     <= 1'b1;
        skid_empty <= 1'b1;
      end else if (in_fire) begin
        main_q <= in_entry;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= in_entry;
      skid_empty <= 1'b0;
    end
  end
`else
  assign IN_READY = !main_v || OUT_READY;
  assign in_fire  = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_v <= 1'b0;
      main_q <= '0;
    end else if (FLUSH) begin
      main_v <= 1'b0;
    end else if (in_fire) begin
      main_q <= in_entry;
      main_v <= 1'b1;
    end else if (out_fire) begin
      main_v <= 1'b0;
    end
  end
`endif

  assign OUT_VALID      = main_v;
  assign OUT_OP1        = main_q.op1;
  assign OUT_OP2        = main_q.op2;
  assign OUT_PC         = main_q.pc;
  assign OUT_STORE_DATA = main_q.store_data;
  assign OUT_FUNC3      = main_q.func3;
  assign OUT_RD         = main_q.rd;
  assign OUT_ALU_SEL    = main_v ? main_q.alu_sel : '0;
  assign OUT_CTRL       = main_v ? main_q.ctrl    : '0;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: randomized traffic against a queue-based reference model.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [4:0]  in_alu, in_rd;
  logic        in_src1_pc, in_src2_imm;
  logic [2:0]  in_f3;
  logic [7:0]  in_ctrl;
  logic [31:0] out_op1, out_op2, out_pc, out_sd;
  logic [4:0]  out_alu, out_rd;
  logic [2:0]  out_f3;
  logic [7:0]  out_ctrl;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(8)) dut (
    .CLK(clk), .RESET(reset), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_PC(in_pc), .IN_RS1_DATA(in_rs1), .IN_RS2_DATA(in_rs2), .IN_IMM(in_imm),
    .IN_ALU_SEL(in_alu), .IN_SRC1_PC(in_src1_pc), .IN_SRC2_IMM(in_src2_imm),
    .IN_FUNC3(in_f3), .IN_RD(in_rd), .IN_CTRL(in_ctrl),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_OP1(out_op1), .OUT_OP2(out_op2), .OUT_ALU_SEL(out_alu),
    .OUT_PC(out_pc), .OUT_STORE_DATA(out_sd),
    .OUT_FUNC3(out_f3), .OUT_RD(out_rd), .OUT_CTRL(out_ctrl)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] op1, op2, pc, sd;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } obs_t;

  // Reference model: FIFO of accepted-but-unconsumed instructions plus the last one shown.
  obs_t q[$];
  obs_t shown;

  function automatic logic model_ready();
`ifdef ID_EX_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic obs_t cur_in();
    obs_t e;
    e.v    = 1'b1;
    e.op1  = in_src1_pc  ? in_pc  : in_rs1;
    e.op2  = in_src2_imm ? in_imm : in_rs2;
    e.pc   = in_pc;
    e.sd   = in_rs2;
    e.alu  = in_alu;
    e.f3   = in_f3;
    e.rd   = in_rd;
    e.ctrl = in_ctrl;
    return e;
  endfunction

  function automatic obs_t exp_obs();
    obs_t e;
    if (q.size() > 0) return q[0];
    e      = shown;
    e.v    = 1'b0;
    e.alu  = '0;
    e.ctrl = '0;
    return e;
  endfunction

  function automatic obs_t dut_obs();
    return {out_valid, out_op1, out_op2, out_pc, out_sd, out_alu, out_f3, out_rd, out_ctrl};
  endfunction

  task automatic rand_in();
    in_pc       = $urandom;
    in_rs1      = $urandom;
    in_rs2      = $urandom;
    in_imm      = $urandom;
    in_alu      = 5'($urandom_range(0, 31));
    in_src1_pc  = 1'($urandom_range(0, 1));
    in_src2_imm = 1'($urandom_range(0, 1));
    in_f3       = 3'($urandom_range(0, 7));
    in_rd       = 5'($urandom_range(0, 31));
    in_ctrl     = 8'($urandom_range(1, 255));
  endtask

  // Advances one clock and applies the same edge to the model; returns at the next negedge.
  task automatic step();
    logic in_f, out_f;
    @(posedge clk);
    if (reset) begin
      q.delete();
      shown = '0;
    end else begin
      in_f  = in_valid && model_ready();
      out_f = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(cur_in());
      end
      if (q.size() > 0) shown = q[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    rand_in();
    step();
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 8'h00) $display("FAIL reset_ctrl got %h exp 00", out_ctrl); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_op1 !== 32'h0) $display("FAIL reset_op1 got %h exp 0", out_op1); else n_pass++;
    n_checks++; if (out_rd !== 5'h0) $display("FAIL reset_rd got %h exp 0", out_rd); else n_pass++;
  endtask

  task automatic test_operand_select();
    out_ready = 1'b1; in_valid = 1'b1;
    in_pc = 32'h100; in_rs1 = 32'h5; in_rs2 = 32'h7; in_imm = 32'hFFFF_FFFC;
    in_src1_pc = 1'b1; in_src2_imm = 1'b1; in_alu = 5'd0; in_f3 = 3'd2; in_rd = 5'd3; in_ctrl = 8'h14;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL sel_imm_valid got %0b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_op1 !== 32'h100) $display("FAIL sel_imm_op1 got %h exp 00000100", out_op1); else n_pass++;
    n_checks++; if (out_op2 !== 32'hFFFF_FFFC) $display("FAIL sel_imm_op2 got %h exp fffffffc", out_op2); else n_pass++;
    n_checks++; if (out_sd !== 32'h7) $display("FAIL sel_imm_store got %h exp 00000007", out_sd); else n_pass++;
    in_src1_pc = 1'b0; in_src2_imm = 1'b0;
    step();
    n_checks++; if (out_op1 !== 32'h5) $display("FAIL sel_reg_op1 got %h exp 00000005", out_op1); else n_pass++;
    n_checks++; if (out_op2 !== 32'h7) $display("FAIL sel_reg_op2 got %h exp 00000007", out_op2); else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bubble_valid got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 8'h00) $display("FAIL bubble_ctrl got %h exp 00", out_ctrl); else n_pass++;
    n_checks++; if (out_alu !== 5'h00) $display("FAIL bubble_alu got %h exp 00", out_alu); else n_pass++;
    n_checks++; if (out_op1 !== 32'h5) $display("FAIL bubble_hold_op1 got %h exp 00000005", out_op1); else n_pass++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rand_in();
      in_valid = 1'b1;
      in_rd = 5'(i);
      step();
      n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'(i))
        $display("FAIL stream_rd%0d got v=%0b rd=%0d exp v=1 rd=%0d", i, out_valid, out_rd, i); else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %0b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    logic ready_pat [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int unsigned accepts_in_stall = 0;
    for (int i = 0; i < 10; i++) begin
      rand_in();
      in_rd = 5'(i + 8);
      in_valid = (i < 6);
      out_ready = ready_pat[i];
      #1;
      n_checks++; if (in_ready !== model_ready())
        $display("FAIL stall_in_ready[%0d] got %0b exp %0b", i, in_ready, model_ready()); else n_pass++;
      if (in_valid && model_ready() && q.size() > 0 && !out_ready) accepts_in_stall++;
      step();
      n_checks++; if (dut_obs() !== exp_obs())
        $display("FAIL stall_out[%0d] got %h exp %h", i, dut_obs(), exp_obs()); else n_pass++;
    end
`ifdef ID_EX_SKID_EN
    n_checks++; if (accepts_in_stall != 1)
      $display("FAIL stall_skid_accepts got %0d exp 1", accepts_in_stall); else n_pass++;
`endif
  endtask

  task automatic test_flush();
    obs_t expect_e;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      in_valid = 1'b1;
      step();
    end
    rand_in();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 8'h00) $display("FAIL flush_ctrl got %h exp 00", out_ctrl); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %0b exp 1", in_ready); else n_pass++;
    rand_in();
    in_rd = 5'd9; in_valid = 1'b1;
    expect_e = cur_in();
    step();
    in_valid = 1'b0;
    n_checks++; if (dut_obs() !== expect_e)
      $display("FAIL flush_next got %h exp %h", dut_obs(), expect_e); else n_pass++;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      in_valid = 1'b1;
      step();
    end
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstfl_valid got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_ctrl !== 8'h00) $display("FAIL rstfl_ctrl got %h exp 00", out_ctrl); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstfl_in_ready got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_op1 !== 32'h0 || out_sd !== 32'h0)
      $display("FAIL rstfl_payload got op1=%h sd=%h exp 0", out_op1, out_sd); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      n_checks++; if (in_ready !== model_ready())
        $display("FAIL rand_in_ready[%0d] got %0b exp %0b", i, in_ready, model_ready()); else n_pass++;
      step();
      n_checks++; if (dut_obs() !== exp_obs())
        $display("FAIL rand_out[%0d] got %h exp %h", i, dut_obs(), exp_obs()); else n_pass++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_in();
    shown = '0;
    @(negedge clk);
    test_reset();
    test_operand_select();
    test_streaming();
    test_stall();
    test_flush();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
